fir_sequencer: RTL and testbench

Sequencing controller that owns one FIR datapath instance and drives its configuration and streaming phases. It validates a tap count, forwards exactly that many coefficients, and waits for the datapath's load-complete flag. It then streams samples one at a time with valid/ready handshakes on both sides and returns each filtered result. It sits between the AXI-facing register/stream logic and the FIR datapath, replacing ad-hoc control toggling with a checked, timeout-guarded FSM.

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_timeout_counter.sv | 28 ++
 rtl/fir_sequencer.sv | 167 ++++++++++++++++
 tb/tb_fir_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR sequencing controller.
package fir_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int MAX_TAPS_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_LOADED,
        ST_RUN,
        ST_WAIT_RESULT,
        ST_ERROR
    } fir_seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_BAD_TAPS   = 2'd1,
        ERR_LOAD_TO    = 2'd2,
        ERR_RESULT_TO  = 2'd3
    } fir_err_code_t;

endpackage

// File: rtl/fir_timeout_counter.sv
// Saturating wait counter: expired_o rises TIMEOUT enabled cycles after the last clear.
// Single cycle clear; no handshake, the owner decides when to enable.
module fir_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int            CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/fir_sequencer.sv
// Configures and streams one FIR datapath: coefficient/sample forwarded 1 cycle after accept,
// result registered 1 cycle after datapath valid; one sample in flight, held until m_ready.
module fir_sequencer
    import fir_pkg::*;
#(
    parameter int MAX_TAPS = MAX_TAPS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [31:0]       cfg_tap_count,
    input  logic              cfg_stop,
    input  logic              err_clear,
    input  logic              coeff_in_valid,
    output logic              coeff_in_ready,
    input  logic [DATA_W-1:0] coeff_in_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [31:0]       tap_count,
    output logic              x_data_valid,
    output logic [DATA_W-1:0] x_data,
    output logic              coeff_data_valid,
    output logic [DATA_W-1:0] coeff_data,
    output logic              compute,
    input  logic              coefficient_loading_complete,
    input  logic              output_data_valid,
    input  logic [DATA_W-1:0] output_data,
    output logic              busy,
    output logic              error,
    output logic [1:0]        err_code
);

    fir_seq_state_t    state_q;
    fir_err_code_t     err_q;
    logic [31:0]       tap_q;
    logic [31:0]       coeff_cnt_q;
    logic [DATA_W-1:0] coeff_data_q;
    logic              coeff_vld_q;
    logic [DATA_W-1:0] x_data_q;
    logic              x_vld_q;
    logic [DATA_W-1:0] m_data_q;
    logic              m_valid_q;
    logic              stop_q;
    logic              waiting;
    logic              expired;

    // Clearing whenever we are not waiting gives a fresh count on every wait-state entry.
    assign waiting = (state_q == ST_WAIT_LOADED) || (state_q == ST_WAIT_RESULT);

    fir_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!waiting),
        .enable_i  (waiting),
        .expired_o (expired)
    );

    assign coeff_in_ready   = (state_q == ST_LOAD);
    assign s_ready          = (state_q == ST_RUN) && !m_valid_q && !stop_q;
    assign compute          = (state_q == ST_RUN) || (state_q == ST_WAIT_RESULT);
    assign busy             = (state_q != ST_IDLE);
    assign error            = (state_q == ST_ERROR);
    assign err_code         = err_q;
    assign tap_count        = tap_q;
    assign coeff_data       = coeff_data_q;
    assign coeff_data_valid = coeff_vld_q;
    assign x_data           = x_data_q;
    assign x_data_valid     = x_vld_q;
    assign m_data           = m_data_q;
    assign m_valid          = m_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            err_q        <= ERR_NONE;
            tap_q        <= '0;
            coeff_cnt_q  <= '0;
            coeff_data_q <= '0;
            coeff_vld_q  <= 1'b0;
            x_data_q     <= '0;
            x_vld_q      <= 1'b0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            stop_q       <= 1'b0;
        end else begin
            coeff_vld_q <= 1'b0;
            x_vld_q     <= 1'b0;
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
            if (cfg_stop && compute) begin
                stop_q <= 1'b1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        if (cfg_tap_count == 32'd0 || cfg_tap_count > 32'(MAX_TAPS)) begin
                            state_q <= ST_ERROR;
                            err_q   <= ERR_BAD_TAPS;
                        end else begin
                            tap_q       <= cfg_tap_count;
                            coeff_cnt_q <= '0;
                            state_q     <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (coeff_in_valid) begin
                        coeff_data_q <= coeff_in_data;
                        coeff_vld_q  <= 1'b1;
                        coeff_cnt_q  <= coeff_cnt_q + 32'd1;
                        if (coeff_cnt_q + 32'd1 == tap_q) begin
                            state_q <= ST_WAIT_LOADED;
                        end
                    end
                end
                ST_WAIT_LOADED: begin
                    if (coefficient_loading_complete) begin
                        state_q <= ST_RUN;
                    end else if (expired) begin
                        state_q <= ST_ERROR;
                        err_q   <= ERR_LOAD_TO;
                    end
                end
                ST_RUN: begin
                    // A pending stop only retires once the last result has been taken.
                    if (stop_q && !m_valid_q) begin
                        state_q <= ST_IDLE;
                        stop_q  <= 1'b0;
                    end else if (s_valid && s_ready) begin
                        x_data_q <= s_data;
                        x_vld_q  <= 1'b1;
                        state_q  <= ST_WAIT_RESULT;
                    end
                end
                ST_WAIT_RESULT: begin
                    if (output_data_valid) begin
                        m_data_q  <= output_data;
                        m_valid_q <= 1'b1;
                        state_q   <= ST_RUN;
                    end else if (expired) begin
                        state_q <= ST_ERROR;
                        err_q   <= ERR_RESULT_TO;
                        stop_q  <= 1'b0;
                    end
                end
                ST_ERROR: begin
                    m_valid_q <= 1'b0;
                    stop_q    <= 1'b0;
                    if (err_clear) begin
                        state_q <= ST_IDLE;
                        err_q   <= ERR_NONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer: tap-count table plus hand-written load/stream/timeout sequences.
module tb_fir_sequencer;

    localparam int DW = 32;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic [31:0]   cfg_tap_count;
    logic          cfg_stop;
    logic          err_clear;
    logic          coeff_in_valid;
    logic          coeff_in_ready;
    logic [DW-1:0] coeff_in_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [31:0]   tap_count;
    logic          x_data_valid;
    logic [DW-1:0] x_data;
    logic          coeff_data_valid;
    logic [DW-1:0] coeff_data;
    logic          compute;
    logic          coefficient_loading_complete;
    logic          output_data_valid;
    logic [DW-1:0] output_data;
    logic          busy;
    logic          error;
    logic [1:0]    err_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_sequencer #(.MAX_TAPS(16), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .cfg_start                    (cfg_start),
        .cfg_tap_count                (cfg_tap_count),
        .cfg_stop                     (cfg_stop),
        .err_clear                    (err_clear),
        .coeff_in_valid               (coeff_in_valid),
        .coeff_in_ready               (coeff_in_ready),
        .coeff_in_data                (coeff_in_data),
        .s_valid                      (s_valid),
        .s_ready                      (s_ready),
        .s_data                       (s_data),
        .m_valid                      (m_valid),
        .m_ready                      (m_ready),
        .m_data                       (m_data),
        .tap_count                    (tap_count),
        .x_data_valid                 (x_data_valid),
        .x_data                       (x_data),
        .coeff_data_valid             (coeff_data_valid),
        .coeff_data                   (coeff_data),
        .compute                      (compute),
        .coefficient_loading_complete (coefficient_loading_complete),
        .output_data_valid            (output_data_valid),
        .output_data                  (output_data),
        .busy                         (busy),
        .error                        (error),
        .err_code                     (err_code)
    );

    typedef struct {
        logic [31:0] taps;
        logic        exp_err;
    } tap_vec_t;

    tap_vec_t vecs [5];

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, 64'(busy), 0);
        chk({tag, " error"}, 64'(error), 0);
        chk({tag, " err_code"}, 64'(err_code), 0);
        chk({tag, " tap_count"}, 64'(tap_count), 0);
        chk({tag, " m_data"}, 64'(m_data), 0);
        chk({tag, " m_valid"}, 64'(m_valid), 0);
        chk({tag, " s_ready"}, 64'(s_ready), 0);
        chk({tag, " coeff_in_ready"}, 64'(coeff_in_ready), 0);
        chk({tag, " compute"}, 64'(compute), 0);
        chk({tag, " x_data_valid"}, 64'(x_data_valid), 0);
        chk({tag, " x_data"}, 64'(x_data), 0);
        chk({tag, " coeff_data_valid"}, 64'(coeff_data_valid), 0);
        chk({tag, " coeff_data"}, 64'(coeff_data), 0);
    endtask

    task automatic start_cfg(input logic [31:0] n);
        cfg_tap_count = n;
        cfg_start     = 1'b1;
        step();
        cfg_start     = 1'b0;
    endtask

    task automatic load_coeffs(input int n, input int base);
        for (int i = 1; i <= n; i++) begin
            coeff_in_valid = 1'b1;
            coeff_in_data  = DW'(base + i);
            step();
            chk("coeff pulse", 64'(coeff_data_valid), 1);
            chk("coeff data", 64'(coeff_data), 64'(base + i));
        end
        coeff_in_valid = 1'b0;
        chk("coeff ready after last", 64'(coeff_in_ready), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{taps: 32'd0,          exp_err: 1'b1};
        vecs[1] = '{taps: 32'd17,         exp_err: 1'b1};
        vecs[2] = '{taps: 32'd16,         exp_err: 1'b0};
        vecs[3] = '{taps: 32'd1,          exp_err: 1'b0};
        vecs[4] = '{taps: 32'hFFFF_FFFF,  exp_err: 1'b1};

        rst = 1'b1; cfg_start = 0; cfg_tap_count = 0; cfg_stop = 0; err_clear = 0;
        coeff_in_valid = 0; coeff_in_data = 0; s_valid = 0; s_data = 0; m_ready = 0;
        coefficient_loading_complete = 0; output_data_valid = 0; output_data = 0;
        step();
        step();
        chk_zero("reset");
        rst = 1'b0;
        step();

        // Tap count validation table
        for (int i = 0; i < 5; i++) begin
            start_cfg(vecs[i].taps);
            chk("tap error", 64'(error), 64'(vecs[i].exp_err));
            chk("tap err_code", 64'(err_code), vecs[i].exp_err ? 64'd1 : 64'd0);
            chk("tap coeff_in_ready", 64'(coeff_in_ready), 64'(!vecs[i].exp_err));
            if (vecs[i].exp_err) begin
                err_clear = 1'b1;
                step();
                err_clear = 1'b0;
                chk("clear busy", 64'(busy), 0);
                chk("clear err_code", 64'(err_code), 0);
            end else begin
                chk("tap latched", 64'(tap_count), 64'(vecs[i].taps));
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk("tap reset", 64'(tap_count), 0);
            end
        end

        // Load 8 coefficients with one idle gap
        start_cfg(32'd8);
        for (int i = 1; i <= 8; i++) begin
            coeff_in_valid = 1'b1;
            coeff_in_data  = DW'(i);
            step();
            chk("load8 pulse", 64'(coeff_data_valid), 1);
            chk("load8 data", 64'(coeff_data), 64'(i));
            if (i == 4) begin
                coeff_in_valid = 1'b0;
                step();
                chk("load8 gap pulse", 64'(coeff_data_valid), 0);
                chk("load8 gap ready", 64'(coeff_in_ready), 1);
            end
        end
        coeff_in_data = 99;
        step();
        chk("extra coeff dropped", 64'(coeff_data_valid), 0);
        coeff_in_valid = 1'b0;
        chk("wait_loaded busy", 64'(busy), 1);
        chk("wait_loaded compute", 64'(compute), 0);
        coefficient_loading_complete = 1'b1;
        step();
        coefficient_loading_complete = 1'b0;
        chk("run compute", 64'(compute), 1);
        chk("run s_ready", 64'(s_ready), 1);
        chk("run busy", 64'(busy), 1);
        start_cfg(32'd3);
        chk("start ignored in run", 64'(tap_count), 8);

        // Sample 5 -> 40, result held under backpressure
        s_valid = 1'b1; s_data = 5;
        step();
        chk("x pulse", 64'(x_data_valid), 1);
        chk("x data", 64'(x_data), 5);
        chk("s_ready in wait", 64'(s_ready), 0);
        s_data = 7;
        step();
        chk("x pulse single", 64'(x_data_valid), 0);
        step();
        output_data_valid = 1'b1; output_data = 40;
        step();
        chk("result valid", 64'(m_valid), 1);
        chk("result data", 64'(m_data), 40);
        chk("s_ready with result", 64'(s_ready), 0);
        output_data = 99;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("hold m_valid", 64'(m_valid), 1);
            chk("hold m_data", 64'(m_data), 40);
            chk("hold s_ready", 64'(s_ready), 0);
            chk("hold no sample", 64'(x_data_valid), 0);
        end
        output_data_valid = 1'b0;
        m_ready = 1'b1; s_valid = 1'b0;
        step();
        m_ready = 1'b0;
        chk("handshake m_valid", 64'(m_valid), 0);
        chk("handshake s_ready", 64'(s_ready), 1);

        // Response arriving on the timeout cycle itself is taken
        s_valid = 1'b1; s_data = 3;
        step();
        s_valid = 1'b0;
        repeat (TO) step();
        chk("edge no error", 64'(error), 0);
        output_data_valid = 1'b1; output_data = 123;
        step();
        output_data_valid = 1'b0;
        chk("edge result valid", 64'(m_valid), 1);
        chk("edge result data", 64'(m_data), 123);
        chk("edge still ok", 64'(error), 0);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;

        // Result timeout
        s_valid = 1'b1; s_data = 4;
        step();
        s_valid = 1'b0;
        repeat (TO) step();
        chk("rto before", 64'(error), 0);
        chk("rto before compute", 64'(compute), 1);
        step();
        chk("rto error", 64'(error), 1);
        chk("rto err_code", 64'(err_code), 3);
        chk("rto compute", 64'(compute), 0);
        chk("rto s_ready", 64'(s_ready), 0);
        chk("rto m_valid", 64'(m_valid), 0);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("rto cleared", 64'(error), 0);
        chk("rto code cleared", 64'(err_code), 0);
        chk("rto idle", 64'(busy), 0);

        // Load-complete timeout
        start_cfg(32'd1);
        load_coeffs(1, 10);
        repeat (TO) step();
        chk("lto before", 64'(error), 0);
        step();
        chk("lto error", 64'(error), 1);
        chk("lto err_code", 64'(err_code), 2);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("lto code cleared", 64'(err_code), 0);

        // Stop while a result is pending
        start_cfg(32'd2);
        load_coeffs(2, 20);
        coefficient_loading_complete = 1'b1;
        step();
        coefficient_loading_complete = 1'b0;
        s_valid = 1'b1; s_data = 9;
        step();
        s_valid = 1'b0;
        cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        output_data_valid = 1'b1; output_data = 77;
        step();
        output_data_valid = 1'b0;
        chk("stop result valid", 64'(m_valid), 1);
        chk("stop result data", 64'(m_data), 77);
        chk("stop busy", 64'(busy), 1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("stop drained", 64'(m_valid), 0);
        chk("stop no new sample", 64'(s_ready), 0);
        step();
        chk("stop idle", 64'(busy), 0);
        chk("stop compute", 64'(compute), 0);

        // Reset in the middle of a load, then a full reload
        start_cfg(32'd8);
        for (int i = 1; i <= 3; i++) begin
            coeff_in_valid = 1'b1;
            coeff_in_data  = DW'(i);
            step();
        end
        coeff_in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero("midload reset");
        start_cfg(32'd8);
        chk("reload tap_count", 64'(tap_count), 8);
        load_coeffs(8, 0);
        coefficient_loading_complete = 1'b1;
        step();
        coefficient_loading_complete = 1'b0;
        chk("reload run", 64'(compute), 1);
        chk("reload busy", 64'(busy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
